// File: rtl/shift_add_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mult_seq
// Purpose  : Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
//            unsigned or two's-complement per operation, START/READY/DONE.
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_mult_seq #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic               CK,
    input  logic               RST,
    input  logic               START,
    input  logic               SIGNED_MODE,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] P,
    output logic               READY,
    output logic               BUSY,
    output logic               DONE,
    output logic [CW-1:0]      CNT
);

    localparam logic [0:0]    ST_IDLE     = 1'b0;
    localparam logic [0:0]    ST_RUN      = 1'b1;
    localparam logic [CW-1:0] C_LAST_STEP = CW'(WIDTH - 1);

    logic [0:0]         r_state_q, w_state_d;
    logic [WIDTH-1:0]   r_areg_q,  w_areg_d;
    logic [WIDTH-1:0]   r_lo_q,    w_lo_d;
    logic [WIDTH:0]     r_hi_q,    w_hi_d;
    logic               r_mode_q,  w_mode_d;
    logic [CW-1:0]      r_cnt_q,   w_cnt_d;
    logic [2*WIDTH-1:0] r_p_q,     w_p_d;
    logic               r_done_q,  w_done_d;

    logic               w_at_last_cnt;
    logic               w_last_step;
    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_hi_shift;
    logic [WIDTH-1:0]   w_lo_shift;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge CK) begin
        if (RST) begin
            r_state_q <= ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_IDLE: if (START)       w_state_d = ST_RUN;
            ST_RUN:  if (w_last_step) w_state_d = ST_IDLE;
            default:                  w_state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        READY = (r_state_q == ST_IDLE);
        BUSY  = (r_state_q != ST_IDLE);
        DONE  = r_done_q;
        CNT   = r_cnt_q;
        P     = r_p_q;
    end

    // ------------------------------------------------------------------------
    // One multiply step: conditional add (or subtract of the sign-bit weight
    // on the last signed step), then a one-bit right shift of {HI,LO}.
    // ------------------------------------------------------------------------
    always_comb begin
        w_at_last_cnt = (r_cnt_q == C_LAST_STEP);
        w_last_step   = (r_state_q == ST_RUN) && w_at_last_cnt;

        if (!r_lo_q[0]) begin
            w_addend = '0;
        end else if (r_mode_q) begin
            w_addend = {r_areg_q[WIDTH-1], r_areg_q};
        end else begin
            w_addend = {1'b0, r_areg_q};
        end

        if (r_mode_q && w_at_last_cnt) begin
            w_sum = r_hi_q - w_addend;
        end else begin
            w_sum = r_hi_q + w_addend;
        end

        w_hi_shift = {r_mode_q & w_sum[WIDTH], w_sum[WIDTH:1]};
        w_lo_shift = {w_sum[0], r_lo_q[WIDTH-1:1]};
    end

    // ------------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------------
    always_comb begin
        w_areg_d = r_areg_q;
        w_lo_d   = r_lo_q;
        w_hi_d   = r_hi_q;
        w_mode_d = r_mode_q;
        w_cnt_d  = r_cnt_q;
        w_p_d    = r_p_q;
        w_done_d = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (START) begin
                    w_areg_d = A;
                    w_lo_d   = B;
                    w_mode_d = SIGNED_MODE;
                    w_hi_d   = '0;
                    w_cnt_d  = '0;
                end
            end
            ST_RUN: begin
                w_hi_d = w_hi_shift;
                w_lo_d = w_lo_shift;
                if (w_last_step) begin
                    w_cnt_d  = '0;
                    w_p_d    = {w_hi_shift[WIDTH-1:0], w_lo_shift};
                    w_done_d = 1'b1;
                end else begin
                    w_cnt_d  = r_cnt_q + 1'b1;
                end
            end
            default: begin
                w_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CK) begin
        if (RST) begin
            r_areg_q <= '0;
            r_lo_q   <= '0;
            r_hi_q   <= '0;
            r_mode_q <= 1'b0;
            r_cnt_q  <= '0;
            r_p_q    <= '0;
            r_done_q <= 1'b0;
        end else begin
            r_areg_q <= w_areg_d;
            r_lo_q   <= w_lo_d;
            r_hi_q   <= w_hi_d;
            r_mode_q <= w_mode_d;
            r_cnt_q  <= w_cnt_d;
            r_p_q    <= w_p_d;
            r_done_q <= w_done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_mult_seq
// Purpose  : Self-checking bench for shift_add_mult_seq (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult_seq;

    localparam int W  = 4;
    localparam int CW = $clog2(W);

    logic           CK = 1'b0;
    logic           RST;
    logic           START;
    logic           SIGNED_MODE;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [2*W-1:0] P;
    logic           READY;
    logic           BUSY;
    logic           DONE;
    logic [CW-1:0]  CNT;

    int             n_checks = 0;
    int             n_errors = 0;
    logic [2*W-1:0] r_prev_p;

    shift_add_mult_seq #(.WIDTH(W)) u_dut (
        .CK          (CK),
        .RST         (RST),
        .START       (START),
        .SIGNED_MODE (SIGNED_MODE),
        .A           (A),
        .B           (B),
        .P           (P),
        .READY       (READY),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .CNT         (CNT)
    );

    always #5 CK = ~CK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: plain integer multiply, truncated to the product width.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic m);
        longint sa, sb, pr;
        if (m) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        pr = sa * sb;
        return pr[2*W-1:0];
    endfunction

    // Issue one op while READY=1; checks timing, CNT, P hold and the result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                          input logic [2*W-1:0] exp, input bit hold);
        START       = 1'b1;
        A           = a;
        B           = b;
        SIGNED_MODE = m;
        chk("ready_before_start", READY, 1);
        tick();
        START = hold;
        for (int k = 0; k < W; k++) begin
            A           = W'($urandom);
            B           = W'($urandom);
            SIGNED_MODE = 1'($urandom);
            chk("busy_in_run", BUSY, 1);
            chk("ready_in_run", READY, 0);
            chk("cnt_step", CNT, k);
            chk("done_in_run", DONE, 0);
            chk("p_hold_in_run", P, r_prev_p);
            tick();
        end
        chk("done_pulse", DONE, 1);
        chk("ready_at_done", READY, 1);
        chk("busy_at_done", BUSY, 0);
        chk("cnt_at_done", CNT, 0);
        chk("product", P, exp);
        r_prev_p = exp;
        START    = 1'b0;
    endtask

    task automatic idle_gap();
        tick();
        chk("done_one_cycle", DONE, 0);
        chk("ready_idle", READY, 1);
        chk("p_hold_idle", P, r_prev_p);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rm;

        RST         = 1'b1;
        START       = 1'b0;
        SIGNED_MODE = 1'b0;
        A           = '0;
        B           = '0;
        r_prev_p    = '0;
        tick();
        tick();
        RST = 1'b0;
        chk("rst_ready", READY, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_cnt", CNT, 0);
        chk("rst_p", P, 0);

        // Directed values
        run_op(4'd13, 4'd11, 1'b0, 8'h8F, 1'b0);
        idle_gap();
        idle_gap();
        run_op(4'hD, 4'h5, 1'b1, 8'hF1, 1'b0);
        idle_gap();
        run_op(4'h8, 4'h8, 1'b1, 8'h40, 1'b0);
        run_op(4'h7, 4'h8, 1'b1, 8'hC8, 1'b0);
        run_op(4'hF, 4'hF, 1'b0, 8'hE1, 1'b0);
        idle_gap();

        // Back-to-back: second START lands in the first op's DONE cycle
        run_op(4'd3, 4'd2, 1'b0, 8'h06, 1'b0);
        run_op(4'd5, 4'd5, 1'b0, 8'h19, 1'b0);
        idle_gap();

        // START held high throughout with changing operands
        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rm = 1'($urandom);
            run_op(ra, rb, rm, ref_mul(ra, rb, rm), 1'b1);
        end
        idle_gap();

        // Reset mid-run at CNT=2: abort, no DONE, P cleared
        START = 1'b1;
        A     = 4'd9;
        B     = 4'd7;
        tick();
        START = 1'b0;
        tick();
        tick();
        chk("abort_cnt_before", CNT, 2);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("abort_ready", READY, 1);
        chk("abort_busy", BUSY, 0);
        chk("abort_p", P, 0);
        chk("abort_done", DONE, 0);
        chk("abort_cnt", CNT, 0);
        r_prev_p = '0;
        for (int i = 0; i < W + 1; i++) begin
            tick();
            chk("abort_no_done", DONE, 0);
            chk("abort_stay_idle", READY, 1);
        end

        // Reset wins over START
        RST   = 1'b1;
        START = 1'b1;
        tick();
        RST   = 1'b0;
        START = 1'b0;
        chk("rst_start_ready", READY, 1);
        chk("rst_start_busy", BUSY, 0);
        tick();
        chk("rst_start_idle", READY, 1);
        chk("rst_start_p", P, 0);

        // Every operand pair in both modes, random gaps and START holding
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < (1 << W); a++) begin
                for (int b = 0; b < (1 << W); b++) begin
                    run_op(W'(a), W'(b), 1'(m), ref_mul(W'(a), W'(b), 1'(m)), 1'($urandom));
                    if ($urandom_range(0, 7) == 0) idle_gap();
                end
            end
        end

        // Random operations
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rm = 1'($urandom);
            run_op(ra, rb, rm, ref_mul(ra, rb, rm), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_gap();
        end
        idle_gap();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
